// File: rtl/aes_keyexp_cache_if.sv
// Bus bundle for aes_keyexp_cache: expansion handshake, round-key read port and shared sbox port.
interface aes_keyexp_cache_if #(
    parameter int unsigned NK = 6
);
    logic              start_i;
    logic [32*NK-1:0]  key_i;
    logic              busy_o;
    logic              ready_o;
    logic [3:0]        rk_idx_i;
    logic              decrypt_i;
    logic [127:0]      rk_o;
    logic              sbox_access_o;
    logic [7:0]        sbox_data_o;
    logic              sbox_decrypt_o;
    logic [7:0]        sbox_data_i;

    // Engine side.
    modport slave (
        input  start_i, key_i, rk_idx_i, decrypt_i, sbox_data_i,
        output busy_o, ready_o, rk_o, sbox_access_o, sbox_data_o, sbox_decrypt_o
    );

    // Host / sbox-mux side.
    modport master (
        output start_i, key_i, rk_idx_i, decrypt_i, sbox_data_i,
        input  busy_o, ready_o, rk_o, sbox_access_o, sbox_data_o, sbox_decrypt_o
    );
endinterface

// File: rtl/aes_keyexp_cache.sv
// AES key expansion engine with round-key cache.
// Expands a 128/192/256-bit key once through a shared byte-serial sbox, then serves any
// round key combinationally by index in encrypt or decrypt order.
module aes_keyexp_cache #(
    parameter int unsigned NK = 6
) (
    input logic               clk,
    input logic               reset,
    aes_keyexp_cache_if.slave bus
);

    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);

    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] MOD_MX = 3'(NK - 1);
    localparam logic [3:0] NR_W   = 4'(NR);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_keyexp_cache: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {StIdle, StExp, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [31:0] r_w [NW];
    logic [5:0]  r_idx;       // word currently being produced
    logic [2:0]  r_mod;       // r_idx % NK, tracked incrementally
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_sub;       // sbox results of bytes 0..2; byte 3 is used straight from the sbox
    logic [7:0]  r_rcon;      // Rcon[r_idx / NK], advanced after each use

    logic        w_accept;
    logic        w_is_rcon;
    logic        w_is_sub;
    logic        w_step;
    logic        w_last;
    logic [31:0] w_temp;
    logic [31:0] w_prev;
    logic [31:0] w_sub_src;
    logic [7:0]  w_sub_byte;
    logic [31:0] w_sub_word;
    logic [31:0] w_new_word;
    logic [3:0]  w_rk_sel;
    logic [5:0]  w_rk_base;

    assign w_accept   = bus.start_i && (r_state != StExp);
    assign w_is_rcon  = (r_mod == 3'd0);
    assign w_is_sub   = w_is_rcon || ((NK == 8) && (r_mod == 3'd4));
    assign w_step     = (r_state == StExp) && (!w_is_sub || (r_byte_cnt == 2'd3));
    assign w_last     = (r_idx == LAST_W);
    assign w_temp     = r_w[r_idx - 6'd1];
    assign w_prev     = r_w[r_idx - NK_W];
    assign w_sub_src  = w_is_rcon ? {w_temp[23:0], w_temp[31:24]} : w_temp;
    assign w_sub_word = {r_sub, bus.sbox_data_i};

    // Pick the byte of the (rotated) previous word that goes to the sbox this cycle, MSB first.
    always_comb begin
        w_sub_byte = 8'h00;
        unique case (r_byte_cnt)
            2'd0: w_sub_byte = w_sub_src[31:24];
            2'd1: w_sub_byte = w_sub_src[23:16];
            2'd2: w_sub_byte = w_sub_src[15:8];
            2'd3: w_sub_byte = w_sub_src[7:0];
            default: w_sub_byte = 8'h00;
        endcase
    end

    // Next schedule word from w[i-NK] and either the substituted or the plain previous word.
    always_comb begin
        w_new_word = w_prev ^ w_temp;
        if (w_is_sub) begin
            w_new_word = w_prev ^ w_sub_word ^ {(w_is_rcon ? r_rcon : 8'h00), 24'h0};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start_i) begin
                    w_state_next = StExp;
                end
            end
            StExp: begin
                if (w_step && w_last) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs: status and sbox request.
    always_comb begin
        bus.busy_o         = (r_state == StExp);
        bus.ready_o        = (r_state == StDone);
        bus.sbox_access_o  = (r_state == StExp) && w_is_sub;
        bus.sbox_data_o    = bus.sbox_access_o ? w_sub_byte : 8'h00;
        bus.sbox_decrypt_o = 1'b0;
    end

    // Expansion counters, staging register and Rcon sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx      <= '0;
            r_mod      <= '0;
            r_byte_cnt <= '0;
            r_sub      <= '0;
            r_rcon     <= 8'h01;
        end else if (w_accept) begin
            r_idx      <= NK_W;
            r_mod      <= '0;
            r_byte_cnt <= '0;
            r_rcon     <= 8'h01;
        end else if (r_state == StExp) begin
            if (w_step) begin
                r_byte_cnt <= '0;
                r_idx      <= r_idx + 6'd1;
                r_mod      <= (r_mod == MOD_MX) ? 3'd0 : r_mod + 3'd1;
                if (w_is_rcon) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
            end else if (w_is_sub) begin
                r_sub      <= {r_sub[15:0], bus.sbox_data_i};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    // Round-key array: cipher key on accept, one derived word per completed step.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned k = 0; k < NK; k++) begin
                r_w[k] <= bus.key_i[32*(NK-1-k) +: 32];
            end
        end else if (w_step) begin
            r_w[r_idx] <= w_new_word;
        end
    end

    // Round-key read port; out-of-range indices read as zero.
    always_comb begin
        w_rk_sel  = bus.decrypt_i ? (NR_W - bus.rk_idx_i) : bus.rk_idx_i;
        w_rk_base = {w_rk_sel, 2'b00};
        bus.rk_o  = '0;
        if (bus.rk_idx_i <= NR_W) begin
            bus.rk_o = {r_w[w_rk_base], r_w[w_rk_base + 6'd1],
                        r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_keyexp_cache.sv
// Self-checking bench for aes_keyexp_cache: one instance per key size, table of round-key
// vectors plus sequences for abort-by-reset and start-while-busy.
module tb_aes_keyexp_cache;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    aes_keyexp_cache_if #(.NK(4)) if4 ();
    aes_keyexp_cache_if #(.NK(6)) if6 ();
    aes_keyexp_cache_if #(.NK(8)) if8 ();

    aes_keyexp_cache #(.NK(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
    aes_keyexp_cache #(.NK(6)) u_dut6 (.clk(clk), .reset(reset), .bus(if6));
    aes_keyexp_cache #(.NK(8)) u_dut8 (.clk(clk), .reset(reset), .bus(if8));

    localparam logic [255:0] KEY4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY8 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEYX = {8{32'hdeadbeef}};

    // GF(2^8) multiply, AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward sbox: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb if4.sbox_data_i = sbox(if4.sbox_data_o);
    always_comb if6.sbox_data_i = sbox(if6.sbox_data_o);
    always_comb if8.sbox_data_i = sbox(if8.sbox_data_o);

    typedef struct {
        int           nk;
        logic [3:0]   idx;
        logic         dec;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_start(input int nk, input logic v);
        case (nk)
            4: if4.start_i = v;
            6: if6.start_i = v;
            default: if8.start_i = v;
        endcase
    endtask

    task automatic set_key(input int nk, input logic [255:0] key);
        case (nk)
            4: if4.key_i = key[127:0];
            6: if6.key_i = key[191:0];
            default: if8.key_i = key;
        endcase
    endtask

    task automatic peek(input int nk, output logic busy, output logic ready, output logic acc);
        case (nk)
            4: begin busy = if4.busy_o; ready = if4.ready_o; acc = if4.sbox_access_o; end
            6: begin busy = if6.busy_o; ready = if6.ready_o; acc = if6.sbox_access_o; end
            default: begin busy = if8.busy_o; ready = if8.ready_o; acc = if8.sbox_access_o; end
        endcase
    endtask

    task automatic read_rk(input int nk, input logic [3:0] idx, input logic dec,
                           output logic [127:0] rk);
        case (nk)
            4: begin if4.rk_idx_i = idx; if4.decrypt_i = dec; end
            6: begin if6.rk_idx_i = idx; if6.decrypt_i = dec; end
            default: begin if8.rk_idx_i = idx; if8.decrypt_i = dec; end
        endcase
        #1;
        case (nk)
            4: rk = if4.rk_o;
            6: rk = if6.rk_o;
            default: rk = if8.rk_o;
        endcase
    endtask

    // Start an expansion and count cycles from the accepting edge to ready_o (bounded).
    // Optionally pulses start_i with another key at cycle inj_at of the expansion.
    task automatic run_exp(input int nk, input logic [255:0] key, input int inj_at,
                           input logic [255:0] inj_key, output int lat, output int nsbox);
        logic busy, ready, acc;
        @(negedge clk);
        set_key(nk, key);
        set_start(nk, 1'b1);
        @(posedge clk);
        #1;
        set_start(nk, 1'b0);
        lat = 0;
        nsbox = 0;
        peek(nk, busy, ready, acc);
        check($sformatf("busy_after_start_nk%0d", nk), {126'd0, busy, ready}, 128'd2);
        while (!ready && lat < 200) begin
            if (acc) nsbox++;
            if (lat == inj_at) begin
                set_key(nk, inj_key);
                set_start(nk, 1'b1);
            end
            if (lat == inj_at + 1) set_start(nk, 1'b0);
            @(posedge clk);
            #1;
            lat++;
            peek(nk, busy, ready, acc);
        end
        check($sformatf("done_status_nk%0d", nk), {125'd0, busy, ready, acc}, 128'd2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic         busy, ready, acc;
        logic [127:0] rk;
        int           lat, nsbox;

        vecs[0]  = '{4, 4'd0,  1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{4, 4'd1,  1'b0, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{4, 4'd2,  1'b0, 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{4, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4]  = '{4, 4'd0,  1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[5]  = '{4, 4'd9,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[6]  = '{4, 4'd11, 1'b0, 128'h0};
        vecs[7]  = '{6, 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202};
        vecs[8]  = '{6, 4'd0,  1'b1, 128'he98ba06f448c773c8ecc720401002202};
        vecs[9]  = '{6, 4'd1,  1'b0, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[10] = '{6, 4'd13, 1'b0, 128'h0};
        vecs[11] = '{6, 4'd13, 1'b1, 128'h0};
        vecs[12] = '{8, 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[13] = '{8, 4'd0,  1'b0, 128'h603deb1015ca71be2b73aef0857d7781};
        vecs[14] = '{8, 4'd1,  1'b0, 128'h1f352c073b6108d72d9810a30914dff4};
        vecs[15] = '{8, 4'd2,  1'b0, 128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[16] = '{8, 4'd12, 1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[17] = '{8, 4'd15, 1'b0, 128'h0};

        reset = 1'b0;
        foreach (vecs[i]) begin end
        set_start(4, 1'b0); set_start(6, 1'b0); set_start(8, 1'b0);
        set_key(4, KEY4);   set_key(6, KEY6);   set_key(8, KEY8);
        if4.rk_idx_i = 4'd0; if4.decrypt_i = 1'b0;
        if6.rk_idx_i = 4'd0; if6.decrypt_i = 1'b0;
        if8.rk_idx_i = 4'd0; if8.decrypt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int n = 4; n <= 8; n += 2) begin
            peek(n, busy, ready, acc);
            check($sformatf("reset_status_nk%0d", n), {125'd0, busy, ready, acc}, 128'd0);
        end
        check("sbox_decrypt_zero", {125'd0, if4.sbox_decrypt_o, if6.sbox_decrypt_o,
                                    if8.sbox_decrypt_o}, 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // Abort an NK=4 expansion by reset at cycle 30, then restart.
        @(negedge clk);
        set_key(4, KEY4);
        set_start(4, 1'b1);
        @(posedge clk);
        #1;
        set_start(4, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        peek(4, busy, ready, acc);
        check("busy_at_cycle30", {127'd0, busy}, 128'd1);
        reset = 1'b0;
        #1;
        peek(4, busy, ready, acc);
        check("abort_status", {125'd0, busy, ready, acc}, 128'd0);
        @(negedge clk);
        reset = 1'b1;

        run_exp(4, KEY4, -10, KEY4, lat, nsbox);
        check("latency_nk4", 128'(lat), 128'd70);
        check("sbox_cycles_nk4", 128'(nsbox), 128'd40);

        // NK=6 with a start pulse (different key) at cycle 20 that must be ignored.
        run_exp(6, KEY6, 20, KEYX, lat, nsbox);
        check("latency_nk6", 128'(lat), 128'd70);
        check("sbox_cycles_nk6", 128'(nsbox), 128'd32);
        set_key(6, KEY6);

        run_exp(8, KEY8, -10, KEY8, lat, nsbox);
        check("latency_nk8", 128'(lat), 128'd91);
        check("sbox_cycles_nk8", 128'(nsbox), 128'd52);

        for (int i = 0; i < 18; i++) begin
            read_rk(vecs[i].nk, vecs[i].idx, vecs[i].dec, rk);
            check($sformatf("rk_vec%0d_nk%0d_idx%0d_dec%0d", i, vecs[i].nk, vecs[i].idx,
                            vecs[i].dec), rk, vecs[i].exp);
        end

        // Cache holds after DONE with no further activity.
        repeat (5) @(posedge clk);
        #1;
        read_rk(4, 4'd10, 1'b0, rk);
        check("rk_hold_nk4", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
